// File: rtl/branch_pattern_table_pkg.sv
// Shared definitions for the branch pattern history table: 2-bit predictor
// state encoding, the table reset state and the PC bit positions used for indexing.
package branch_pattern_table_pkg;

    // 2-bit saturating-style predictor states; bit 1 is the predicted direction
    typedef enum logic [1:0] {
        StrongNotTaken = 2'b00,
        WeakNotTaken   = 2'b01,
        WeakTaken      = 2'b10,
        StrongTaken    = 2'b11
    } pht_state_e;

    localparam logic [1:0] RESET_STATE = WeakNotTaken;

    // Instructions are word aligned, so the index starts above the byte offset
    localparam int unsigned IDX_LSB = 2;

endpackage

// File: rtl/dynamic_branch_predictor.sv
// 2-bit predictor transition function: maps the current state and whether
// that state mispredicted the resolved branch onto the next state.
module dynamic_branch_predictor
    import branch_pattern_table_pkg::*;
(
    input  logic [1:0] state,
    input  logic       mispredicted,
    output logic [1:0] next_state
);

    // Next-state decode; weak states jump across on a miss, strong states decay to weak
    always_comb begin
        next_state = state;
        unique case (pht_state_e'(state))
            StrongNotTaken: next_state = mispredicted ? WeakNotTaken   : StrongNotTaken;
            WeakNotTaken:   next_state = mispredicted ? StrongTaken    : StrongNotTaken;
            StrongTaken:    next_state = mispredicted ? WeakTaken      : StrongTaken;
            WeakTaken:      next_state = mispredicted ? StrongNotTaken : StrongTaken;
        endcase
    end

endmodule

// File: rtl/branch_pattern_table.sv
// Pattern history table for the 2-bit dynamic branch predictor. Fetch reads a
// registered prediction one cycle after lookup; execute resolves branches with
// a single-cycle read-modify-write. Same-index lookup/update bypasses the new state.
// Optional global-history hashing is enabled by defining GSHARE_EN.
module branch_pattern_table
    import branch_pattern_table_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lookup_valid,
    input  logic [PC_WIDTH-1:0]   lookup_pc,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [1:0]            pred_state,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic                  upd_taken,
    output logic                  upd_mispredicted,
    output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            table_q [ENTRIES];
    logic                  pred_valid_q;
    logic [1:0]            pred_state_q;
    logic [INDEX_BITS-1:0] pred_index_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic [INDEX_BITS-1:0] pc_index;
    logic [INDEX_BITS-1:0] lookup_index;
    logic [1:0]            upd_state;
    logic [1:0]            upd_next_state;
    logic                  state_miss;
    logic [1:0]            lookup_state;

    assign pc_index = lookup_pc[IDX_LSB +: INDEX_BITS];

    // PC bits outside the index field do not participate in lookup
    logic unused_pc;
    assign unused_pc = ^{lookup_pc[PC_WIDTH-1:INDEX_BITS+IDX_LSB], lookup_pc[IDX_LSB-1:0]};

`ifdef GSHARE_EN
    logic [INDEX_BITS-1:0] ghr_q;

    // Lookup hashes with the history as it stands before this cycle's update
    assign lookup_index = pc_index ^ ghr_q;

    // Global history: shift in each resolved outcome
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (upd_valid) begin
            ghr_q <= {ghr_q[INDEX_BITS-2:0], upd_taken};
        end
    end
`else
    assign lookup_index = pc_index;
`endif

    assign upd_state        = table_q[upd_index];
    assign state_miss       = upd_state[1] != upd_taken;
    assign upd_mispredicted = upd_valid && state_miss;

    dynamic_branch_predictor u_fsm (
        .state        (upd_state),
        .mispredicted (state_miss),
        .next_state   (upd_next_state)
    );

    // Bypass the state being written this cycle so fetch never sees a stale entry
    always_comb begin
        lookup_state = table_q[lookup_index];
        if (upd_valid && (upd_index == lookup_index)) begin
            lookup_state = upd_next_state;
        end
    end

    // Table storage; reset reinitialises every entry and drops any in-flight update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                table_q[i] <= RESET_STATE;
            end
        end else if (upd_valid) begin
            table_q[upd_index] <= upd_next_state;
        end
    end

    // Prediction register; fields hold when no lookup is issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid_q <= 1'b0;
            pred_state_q <= RESET_STATE;
            pred_index_q <= '0;
        end else begin
            pred_valid_q <= lookup_valid;
            if (lookup_valid) begin
                pred_state_q <= lookup_state;
                pred_index_q <= lookup_index;
            end
        end
    end

    // Saturating mispredict statistics counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (upd_mispredicted && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign pred_valid     = pred_valid_q;
    assign pred_state     = pred_state_q;
    assign pred_taken     = pred_state_q[1];
    assign pred_index     = pred_index_q;
    assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_pattern_table.sv
// Self-checking bench for branch_pattern_table: table-driven vectors with a
// reference model and a prediction scoreboard, plus saturation, reset and
// (when GSHARE_EN is defined) history-hashing sequences.
module tb_branch_pattern_table;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        pred_valid;
    logic        pred_taken;
    logic [1:0]  pred_state;
    logic [5:0]  pred_index;
    logic        upd_valid = 1'b0;
    logic [5:0]  upd_index = '0;
    logic        upd_taken = 1'b0;
    logic        upd_mispredicted;
    logic [15:0] mispredict_cnt;

    branch_pattern_table #(
        .INDEX_BITS (6),
        .PC_WIDTH   (32),
        .CNT_WIDTH  (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .lookup_valid     (lookup_valid),
        .lookup_pc        (lookup_pc),
        .pred_valid       (pred_valid),
        .pred_taken       (pred_taken),
        .pred_state       (pred_state),
        .pred_index       (pred_index),
        .upd_valid        (upd_valid),
        .upd_index        (upd_index),
        .upd_taken        (upd_taken),
        .upd_mispredicted (upd_mispredicted),
        .mispredict_cnt   (mispredict_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [1:0]  m_table [64];
    logic [15:0] m_cnt;
    logic [5:0]  m_ghr;
    logic [1:0]  m_last_state;
    logic [5:0]  m_last_index;

    typedef struct {
        logic [5:0] idx;
        logic [1:0] st;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        lv;
        logic [31:0] pc;
        logic        uv;
        logic [5:0]  ui;
        logic        ut;
        logic        exp_mp;
        logic [1:0]  exp_state;
        logic [15:0] exp_cnt;
    } vec_t;
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Transition rules written out case by case
    function automatic logic [1:0] model_next(input logic [1:0] s, input logic taken);
        logic mp;
        mp = (s[1] != taken);
        case (s)
            2'b00:   return mp ? 2'b01 : 2'b00;
            2'b01:   return mp ? 2'b11 : 2'b00;
            2'b11:   return mp ? 2'b10 : 2'b11;
            default: return mp ? 2'b00 : 2'b11;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_table[i] = 2'b01;
        m_cnt        = '0;
        m_ghr        = '0;
        m_last_state = 2'b01;
        m_last_index = '0;
        sb.delete();
    endtask

    // One clock: drive at posedge+1, check combinational flag mid-cycle,
    // check registered outputs at the next posedge+1.
    task automatic cycle(input logic lv, input logic [31:0] pc, input logic uv,
                         input logic [5:0] ui, input logic ut, input logic en,
                         output logic got_mp);
        logic [5:0] li;
        logic [1:0] nst;
        logic [1:0] ls;
        logic       mp;
        exp_t       e;
        lookup_valid = lv;
        lookup_pc    = pc;
        upd_valid    = uv;
        upd_index    = ui;
        upd_taken    = ut;
        #2;
        got_mp = upd_mispredicted;
        mp  = uv && (m_table[ui][1] != ut);
        nst = model_next(m_table[ui], ut);
        li  = pc[7:2] ^ m_ghr;
        ls  = (uv && ui == li) ? nst : m_table[li];
        if (en) check("upd_mispredicted", {31'd0, got_mp}, {31'd0, mp});
        if (lv) begin
            e.idx = li;
            e.st  = ls;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (uv) begin
            m_table[ui] = nst;
`ifdef GSHARE_EN
            m_ghr = {m_ghr[4:0], ut};
`endif
        end
        if (mp && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (en) check("pred_valid", {31'd0, pred_valid}, {31'd0, lv});
        if (lv) begin
            if (sb.size() == 0) begin
                check("scoreboard_nonempty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                m_last_state = e.st;
                m_last_index = e.idx;
            end
        end
        if (en) begin
            check("pred_state", {30'd0, pred_state}, {30'd0, m_last_state});
            check("pred_taken", {31'd0, pred_taken}, {31'd0, m_last_state[1]});
            check("pred_index", {26'd0, pred_index}, {26'd0, m_last_index});
            check("mispredict_cnt", {16'd0, mispredict_cnt}, {16'd0, m_cnt});
        end
    endtask

    task automatic idle();
        lookup_valid = 1'b0;
        upd_valid    = 1'b0;
    endtask

    initial begin
        logic mp;
        int   n;

        // Test-plan vectors: {lv, pc, uv, idx, taken, exp_mp, exp_state, exp_cnt}
        vecs[0]  = '{1'b1, 32'h100, 1'b0, 6'd0, 1'b0, 1'b0, 2'b01, 16'd0};
        vecs[1]  = '{1'b0, 32'h0,   1'b1, 6'd0, 1'b1, 1'b1, 2'b00, 16'd1};
        vecs[2]  = '{1'b0, 32'h0,   1'b1, 6'd0, 1'b1, 1'b0, 2'b00, 16'd1};
        vecs[3]  = '{1'b0, 32'h0,   1'b1, 6'd0, 1'b1, 1'b0, 2'b00, 16'd1};
        vecs[4]  = '{1'b1, 32'h100, 1'b0, 6'd0, 1'b0, 1'b0, 2'b11, 16'd1};
        vecs[5]  = '{1'b0, 32'h0,   1'b1, 6'd0, 1'b0, 1'b1, 2'b00, 16'd2};
        vecs[6]  = '{1'b0, 32'h0,   1'b1, 6'd0, 1'b0, 1'b1, 2'b00, 16'd3};
        vecs[7]  = '{1'b1, 32'h100, 1'b0, 6'd0, 1'b0, 1'b0, 2'b00, 16'd3};
        vecs[8]  = '{1'b1, 32'h104, 1'b1, 6'd1, 1'b1, 1'b1, 2'b11, 16'd4};
        vecs[9]  = '{1'b1, 32'h108, 1'b1, 6'd1, 1'b0, 1'b1, 2'b01, 16'd5};
        vecs[10] = '{1'b1, 32'h104, 1'b0, 6'd0, 1'b0, 1'b0, 2'b10, 16'd5};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_pred_valid", {31'd0, pred_valid}, 32'd0);
        check("reset_pred_state", {30'd0, pred_state}, 32'd1);
        check("reset_pred_index", {26'd0, pred_index}, 32'd0);
        check("reset_cnt", {16'd0, mispredict_cnt}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

`ifndef GSHARE_EN
        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].lv, vecs[i].pc, vecs[i].uv, vecs[i].ui, vecs[i].ut, 1'b1, mp);
            check("vec_mispred", {31'd0, mp}, {31'd0, vecs[i].exp_mp});
            if (vecs[i].lv) check("vec_state", {30'd0, pred_state}, {30'd0, vecs[i].exp_state});
            check("vec_cnt", {16'd0, mispredict_cnt}, {16'd0, vecs[i].exp_cnt});
        end
        // Lookup idle holds the last prediction fields
        cycle(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1, mp);
`else
        // Taken, taken, not-taken builds history 000110
        cycle(1'b0, 32'h0, 1'b1, 6'd0, 1'b1, 1'b1, mp);
        cycle(1'b0, 32'h0, 1'b1, 6'd0, 1'b1, 1'b1, mp);
        cycle(1'b0, 32'h0, 1'b1, 6'd0, 1'b0, 1'b1, mp);
        cycle(1'b1, 32'h100, 1'b0, 6'd0, 1'b0, 1'b1, mp);
        check("gshare_pred_index", {26'd0, pred_index}, {26'd0, 6'b000110});
`endif

        // Drive the counter to saturation with a miss-every-time pattern on one entry
        n = 0;
        while (m_cnt != 16'hFFFF && n < 70000) begin
            cycle(1'b0, 32'h0, 1'b1, 6'd10, (n % 4 == 0) || (n % 4 == 3), 1'b0, mp);
            n++;
        end
        idle();
        #1;
        check("cnt_saturated", {16'd0, mispredict_cnt}, 32'h0000_FFFF);
        // Entry 10 is now back at WEAK_NOT_TAKEN or later in the cycle; force a known miss
        cycle(1'b0, 32'h0, 1'b1, 6'd10, ~m_table[10][1], 1'b1, mp);
        check("cnt_extra_miss_flag", {31'd0, mp}, 32'd1);
        check("cnt_holds_max", {16'd0, mispredict_cnt}, 32'h0000_FFFF);

        // Mid-stream reset with a lookup already registered and an update in flight
        cycle(1'b1, 32'h114, 1'b0, 6'd0, 1'b0, 1'b1, mp);
        upd_valid    = 1'b1;
        upd_index    = 6'd5;
        upd_taken    = 1'b1;
        lookup_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_pred_valid", {31'd0, pred_valid}, 32'd0);
        check("async_cnt", {16'd0, mispredict_cnt}, 32'd0);
        check("async_pred_state", {30'd0, pred_state}, 32'd1);
        check("async_pred_index", {26'd0, pred_index}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        model_reset();
        for (int i = 0; i < 64; i++) begin
            cycle(1'b1, i << 2, 1'b0, 6'd0, 1'b0, 1'b1, mp);
        end

        if (sb.size() != 0) check("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_pattern_table.md
Name: branch_pattern_table

Overview:
Pattern history table that sits on the fetch and resolve sides of the 2-bit dynamic branch predictor.
- The fetch stage reads a per-entry 2-bit state and receives a registered taken/not-taken prediction.
- The execute stage returns the actual outcome. The block derives the mispredict flag, applies the 2-bit transition rules and writes the new state back.
- The block is the consumer of the predictor state encoding and transition FSM.

Parameters:
- INDEX_BITS, 6, log2 of table entries (64 entries).
- PC_WIDTH, 32, width of the fetch PC.
- CNT_WIDTH, 16, width of the saturating mispredict statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- lookup_valid  in  1  fetch lookup request this cycle.
- lookup_pc  in  PC_WIDTH  fetch PC; index = lookup_pc[INDEX_BITS+1:2].
- pred_valid  out  1  prediction valid; registered, one cycle after lookup_valid.
- pred_taken  out  1  predicted direction (state bit 1).
- pred_state  out  2  state used for the prediction.
- pred_index  out  INDEX_BITS  index used; carried down the pipe and returned as upd_index.
- upd_valid  in  1  branch resolved this cycle.
- upd_index  in  INDEX_BITS  entry to update.
- upd_taken  in  1  actual branch outcome.
- upd_mispredicted  out  1  combinational; stored state's direction != upd_taken, gated by upd_valid.
- mispredict_cnt  out  CNT_WIDTH  saturating count of updates with upd_mispredicted=1.

Behaviour:
- Encoding: STRONG_NOT_TAKEN=2'b00, WEAK_NOT_TAKEN=2'b01, WEAK_TAKEN=2'b10, STRONG_TAKEN=2'b11. Prediction is taken when state[1]=1.
- Transitions, with mispredicted = (state[1] != upd_taken):
  - SNT: mispredicted -> WNT, else SNT.
  - WNT: mispredicted -> ST, else SNT.
  - ST: mispredicted -> WT, else ST.
  - WT: mispredicted -> SNT, else ST.
- Reset (async, immediate):
  - All entries = WEAK_NOT_TAKEN.
  - pred_valid=0, pred_taken=0, pred_state=2'b01, pred_index=0, mispredict_cnt=0.
- Lookup:
  - Latency 1.
  - On an edge with lookup_valid=1: pred_* load from the indexed entry and pred_valid=1.
  - lookup_valid=0: pred_valid=0 and other pred_* hold their values.
- Update:
  - Read-modify-write in a single cycle: combinational read of upd_index, new state written on the same edge.
  - Only one update per cycle.
- Same-cycle lookup and update to the same index: the prediction uses the post-update (next) state (bypass). A different index needs no interaction.
- mispredict_cnt increments on each upd_valid with a mispredict and saturates at all-ones; it does not wrap.
- Reset asserted mid-operation: any in-flight update is discarded and the table is reinitialised. pred_valid drops asynchronously.
- upd_index is used as supplied; no range check is needed, because the full index space is populated.

Optional Feature:
GSHARE_EN
- Defined:
  - Adds an INDEX_BITS-wide global history register, reset to 0.
  - Lookup index = lookup_pc[INDEX_BITS+1:2] XOR ghr; pred_index reports the hashed index.
  - On upd_valid the history shifts left with upd_taken inserted at bit 0.
  - Same-cycle lookup uses the pre-shift history.
- Undefined: plain PC indexing; no history register exists.

Decomposition:
- Shared package/defines: the four state encodings, the reset state (WEAK_NOT_TAKEN) and the index-extraction bit positions.
- The next-state computation comes from the existing 2-bit transition FSM (dynamic_branch_predictor). It is instantiated once on the update path, fed the stored state and the derived mispredicted flag. No new sub-module is created.
- The table array, bypass mux and counter stay in this module.

Test Plan:
- Reset, then lookup pc=0x100 (index 0) -> next cycle pred_valid=1, pred_state=01, pred_taken=0; mispredict_cnt=0.
- Update index 0 with upd_taken=1 three times -> upd_mispredicted=1,0,0; entry goes 01->11->11->11; mispredict_cnt=1.
- From STRONG_TAKEN, update index 0 with upd_taken=0 twice -> 11->10->00; upd_mispredicted=1,1; mispredict_cnt increases by 2.
- Same cycle: lookup pc=0x104 (index 1, state 01) and update index 1 with taken=1 -> pred_state=11, pred_taken=1 (bypass).
- Force mispredict_cnt to 16'hFFFF, then issue a further mispredict -> stays 16'hFFFF. Assert rst mid-stream -> pred_valid=0 immediately, all entries read back as 01.
- With GSHARE_EN: updates taken, taken, not-taken -> ghr=6'b000110. A lookup with pc=0x100 then reports pred_index=6'b000110.
